stage_mem_hs: RTL and testbench
===============================

# stage_mem_hs

Parametrised memory stage for the br32 pipeline that replaces the fixed single-cycle memory/IO access with a request/grant/response bus handshake. It holds one instruction from EX, aligns sub-word stores into byte lanes, extracts and sign/zero-extends sub-word loads, detects misalignment and bus timeout, and stalls upstream until the access completes. It sits between the EX and WB stages and produces the same result/rd/w_rd/bubble bundle WB consumes today.

## Interface
- IO_AW, 16: IO address width; `bus_addr` for IO = zero-extended `alu_res[IO_AW-1:0]`.
- POSTED_WRITES, 1: 1 = a store/IO write completes at grant; 0 = it waits for `rsp_valid`.
- TIMEOUT, 255: maximum cycles spent in RESP before an error; 0 disables the timeout.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- ex_pc, ex_nextpc, ex_alu_res, ex_op3  in  32 each  EX bundle: pc, link value, address/ALU result, store data.
- ex_rd  in  5;  ex_w_rd, ex_link, ex_mem_r, ex_mem_w, ex_mem_sx, ex_io_r, ex_io_w, ex_bubble  in  1 each.
- ex_mem_sz  in  2  0 = byte, 1 = half, 2/3 = word.
- stall_o  out  1  upstream must hold EX and not advance.
- bus_req, bus_we, bus_io  out  1 each  request valid, write, IO space.
- bus_addr  out  32;  bus_be  out  4;  bus_wdata  out  32.
- bus_gnt  in  1;  rsp_valid  in  1;  rsp_data  in  32.
- out_pc, out_res  out  32;  out_rd  out  5;  out_w_rd, out_bubble  out  1.
- misalign_o, buserr_o  out  1  one-cycle fault pulses, valid in DONE only.

## Operation
- Slot register loads all `ex_*` fields on every edge where `stall_o=0`; `slot_bubble <= ex_bubble || rst`.
- A bus op is any of mem_r, mem_w, io_r, io_w with `slot_bubble=0`.
- States:
  - IDLE: slot is empty or holds a non-bus op.
  - REQ: `bus_req=1`, bus outputs stable.
  - RESP: waiting for `rsp_valid`.
  - DONE: completed bus op is presented to WB.
- Transitions on load (from IDLE or DONE):
  - bus op, aligned → REQ.
  - bus op, misaligned → DONE with fault.
  - otherwise → IDLE.
- REQ with `bus_gnt`:
  - write and POSTED_WRITES=1 → DONE.
  - otherwise → RESP.
- RESP:
  - `rsp_valid` → capture `rsp_data`, go to DONE.
  - wait counter reaches TIMEOUT → DONE with buserr.
- DONE with no new load → IDLE.
- stall_o = (state is REQ or RESP) OR (state is IDLE/DONE and the slot was just loaded with a bus op, i.e. the next state is REQ or a misaligned DONE). Implementation: stall_o = `state==REQ || state==RESP`; load edges leave stall low.
- Misaligned: half with `a[0]=1`, or word with `a[1:0]≠0`, where a = alu_res. IO accesses are word and must have `a[1:0]=0`. On misalign: no bus request, `misalign_o=1` in DONE, `out_w_rd=0`.
- Store lanes:
  - `bus_wdata = op3 << 8*a[1:0]`.
  - `bus_be`: byte = 0001<<a, half = 0011<<a, word = 1111.
- Load extract: `d = rsp_q >> 8*a[1:0]`, then sign-extend (mem_sx=1) or zero-extend to the access size. IO reads take `rsp_q` unshifted.
- out_res priority: link → nextpc; mem_r → extracted load; io_r → rsp_q; else alu_res. On buserr the result is 0.
- out_w_rd = w_rd && !slot_bubble && no fault && (state is IDLE or DONE).
- out_bubble = slot_bubble OR state is REQ or RESP.
- rsp_valid in IDLE, REQ or DONE is ignored.

## Timing
- Reset values (next edge after rst=1):
  - state IDLE, slot_bubble 1.
  - stall_o, bus_req, out_w_rd, misalign_o, buserr_o all 0.
  - out_bubble 1; all data outputs 0.
- Reset mid-transaction abandons it; any later response is ignored.
- Non-bus op: result in the cycle after load; throughput 1/cycle.
- Load with immediate grant and rsp_valid on the next cycle: load edge → REQ (1 cycle) → RESP (1 cycle) → DONE. Result appears 3 cycles after load.
- Posted write with immediate grant: result after 2 cycles.
- The bus must not return `rsp_valid` in the grant cycle.
- Bus outputs are held constant from the first REQ cycle until grant.
- Timeout counter:
  - 8+ bit, cleared on REQ→RESP, increments each RESP cycle.
  - Error fires when the count equals TIMEOUT with no `rsp_valid`.
  - `rsp_valid` in the same cycle as the timeout wins.
- Back-to-back: in DONE, `stall_o=0`, so the next instruction loads on the same edge that retires the current one.

## Test plan
- ALU op, alu_res=0x1234, w_rd=1, rd=5 → the next cycle out_res=0x1234, out_w_rd=1, stall_o=0, bus_req=0.
- lb, a=0x103, rsp_data=0x80FF_FF11 returned 2 cycles after grant, sx=1 → bus_be=0000 ignored on read; stall_o high for 4 cycles; out_res=0xFFFF_FF80.
- sh, a=0x202, op3=0xABCD, POSTED_WRITES=1, grant after 3 cycles → bus_be=1100, bus_wdata=0xABCD_0000; DONE one cycle after grant.
- lw, a=0x101 → no bus_req; misalign_o=1 one cycle later; out_w_rd=0.
- io_r with TIMEOUT=4 and no response → buserr_o=1 after 4 RESP cycles, out_res=0, then the pipeline resumes.
- rst asserted in RESP followed by a late rsp_valid → state IDLE, out_bubble=1, no write-back.

Source files
------------

// File: rtl/stage_mem_hs.sv
// rtl/stage_mem_hs.sv - br32 memory stage with request/grant/response bus handshake
`timescale 1ns/1ps
module stage_mem_hs #(
    parameter int IO_AW         = 16,
    parameter bit POSTED_WRITES = 1'b1,
    parameter int TIMEOUT       = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_nextpc,
    input  logic [31:0] ex_alu_res,
    input  logic [31:0] ex_op3,
    input  logic [4:0]  ex_rd,
    input  logic        ex_w_rd,
    input  logic        ex_link,
    input  logic        ex_mem_r,
    input  logic        ex_mem_w,
    input  logic        ex_mem_sx,
    input  logic        ex_io_r,
    input  logic        ex_io_w,
    input  logic        ex_bubble,
    input  logic [1:0]  ex_mem_sz,
    output logic        stall_o,
    output logic        bus_req,
    output logic        bus_we,
    output logic        bus_io,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_data,
    output logic [31:0] out_pc,
    output logic [31:0] out_res,
    output logic [4:0]  out_rd,
    output logic        out_w_rd,
    output logic        out_bubble,
    output logic        misalign_o,
    output logic        buserr_o
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;

    localparam int          CW      = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);
    localparam logic [31:0] IO_MASK = (IO_AW >= 32) ? 32'hFFFF_FFFF : ((32'h1 << IO_AW) - 32'h1);

    state_t        r_state;
    logic [31:0]   r_pc, r_nextpc, r_alu, r_op3, r_rsp;
    logic [4:0]    r_rd;
    logic [1:0]    r_sz;
    logic          r_w_rd, r_link, r_mem_r, r_mem_w, r_sx, r_io_r, r_io_w, r_bubble;
    logic [CW-1:0] r_cnt;
    logic          r_mis, r_berr;

    logic          w_load, w_ex_bus, w_ex_mis, w_we, w_io, w_req, w_timeout;
    logic [CW-1:0] w_cnt_nx;
    logic [4:0]    w_lsh;
    logic [31:0]   w_shift, w_ld, w_res;
    logic [3:0]    w_be;

    assign w_load    = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_ex_bus  = (ex_mem_r || ex_mem_w || ex_io_r || ex_io_w) && !ex_bubble;
    assign w_we      = r_mem_w || r_io_w;
    assign w_io      = r_io_r || r_io_w;
    assign w_req     = (r_state == S_REQ);
    assign w_cnt_nx  = r_cnt + CW'(1);
    assign w_timeout = (TIMEOUT != 0) && (w_cnt_nx == TO_VAL);
    assign w_lsh     = {r_alu[1:0], 3'b000};
    assign w_shift   = r_rsp >> w_lsh;

    // IO space is word-only, so any low address bit set is a fault there.
    always_comb begin
        w_ex_mis = 1'b0;
        if (ex_io_r || ex_io_w) begin
            w_ex_mis = |ex_alu_res[1:0];
        end else begin
            case (ex_mem_sz)
                2'd0:    w_ex_mis = 1'b0;
                2'd1:    w_ex_mis = ex_alu_res[0];
                default: w_ex_mis = |ex_alu_res[1:0];
            endcase
        end
    end

    always_comb begin
        w_ld = w_shift;
        case (r_sz)
            2'd0:    w_ld = {{24{r_sx & w_shift[7]}}, w_shift[7:0]};
            2'd1:    w_ld = {{16{r_sx & w_shift[15]}}, w_shift[15:0]};
            default: w_ld = w_shift;
        endcase
    end

    always_comb begin
        w_res = r_alu;
        if (r_berr)       w_res = 32'h0;
        else if (r_link)  w_res = r_nextpc;
        else if (r_mem_r) w_res = w_ld;
        else if (r_io_r)  w_res = r_rsp;
    end

    always_comb begin
        w_be = 4'b0000;
        if (w_we) begin
            if (w_io) begin
                w_be = 4'b1111;
            end else begin
                case (r_sz)
                    2'd0:    w_be = 4'b0001 << r_alu[1:0];
                    2'd1:    w_be = 4'b0011 << r_alu[1:0];
                    default: w_be = 4'b1111;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_pc     <= '0;
            r_nextpc <= '0;
            r_alu    <= '0;
            r_op3    <= '0;
            r_rd     <= '0;
            r_sz     <= '0;
            r_w_rd   <= 1'b0;
            r_link   <= 1'b0;
            r_mem_r  <= 1'b0;
            r_mem_w  <= 1'b0;
            r_sx     <= 1'b0;
            r_io_r   <= 1'b0;
            r_io_w   <= 1'b0;
            r_bubble <= 1'b1;
            r_rsp    <= '0;
            r_cnt    <= '0;
            r_mis    <= 1'b0;
            r_berr   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_pc     <= ex_pc;
                    r_nextpc <= ex_nextpc;
                    r_alu    <= ex_alu_res;
                    r_op3    <= ex_op3;
                    r_rd     <= ex_rd;
                    r_sz     <= ex_mem_sz;
                    r_w_rd   <= ex_w_rd;
                    r_link   <= ex_link;
                    r_mem_r  <= ex_mem_r;
                    r_mem_w  <= ex_mem_w;
                    r_sx     <= ex_mem_sx;
                    r_io_r   <= ex_io_r;
                    r_io_w   <= ex_io_w;
                    r_bubble <= ex_bubble;
                    r_berr   <= 1'b0;
                    r_mis    <= w_ex_bus && w_ex_mis;
                    if (w_ex_bus && w_ex_mis) r_state <= S_DONE;
                    else if (w_ex_bus)        r_state <= S_REQ;
                    else                      r_state <= S_IDLE;
                end
                S_REQ: begin
                    if (bus_gnt) begin
                        r_cnt <= '0;
                        if (w_we && POSTED_WRITES) r_state <= S_DONE;
                        else                       r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_cnt <= w_cnt_nx;
                    // A response arriving in the timeout cycle still counts as success.
                    if (rsp_valid) begin
                        r_rsp   <= rsp_data;
                        r_state <= S_DONE;
                    end else if (w_timeout) begin
                        r_berr  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign stall_o    = (r_state == S_REQ) || (r_state == S_RESP);
    assign bus_req    = w_req;
    assign bus_we     = w_req && w_we;
    assign bus_io     = w_req && w_io;
    assign bus_addr   = !w_req ? 32'h0 : (w_io ? (r_alu & IO_MASK) : r_alu);
    assign bus_be     = w_req ? w_be : 4'b0000;
    assign bus_wdata  = w_req ? (r_op3 << w_lsh) : 32'h0;
    assign out_pc     = r_pc;
    assign out_res    = w_res;
    assign out_rd     = r_rd;
    assign out_w_rd   = r_w_rd && !r_bubble && !r_mis && !r_berr && w_load;
    assign out_bubble = r_bubble || stall_o;
    assign misalign_o = (r_state == S_DONE) && r_mis;
    assign buserr_o   = (r_state == S_DONE) && r_berr;
endmodule

// File: tb/tb_stage_mem_hs.sv
// tb/tb_stage_mem_hs.sv - self-checking bench for stage_mem_hs
`timescale 1ns/1ps
module tb_stage_mem_hs;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ex_pc, ex_nextpc, ex_alu_res, ex_op3;
    logic [4:0]  ex_rd;
    logic        ex_w_rd, ex_link, ex_mem_r, ex_mem_w, ex_mem_sx, ex_io_r, ex_io_w, ex_bubble;
    logic [1:0]  ex_mem_sz;
    logic        stall_o, bus_req, bus_we, bus_io;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_gnt, rsp_valid;
    logic [31:0] rsp_data;
    logic [31:0] out_pc, out_res;
    logic [4:0]  out_rd;
    logic        out_w_rd, out_bubble, misalign_o, buserr_o;

    always #5 clk = ~clk;

    stage_mem_hs #(.IO_AW(16), .POSTED_WRITES(1'b1), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ex_pc(ex_pc), .ex_nextpc(ex_nextpc), .ex_alu_res(ex_alu_res), .ex_op3(ex_op3),
        .ex_rd(ex_rd), .ex_w_rd(ex_w_rd), .ex_link(ex_link), .ex_mem_r(ex_mem_r),
        .ex_mem_w(ex_mem_w), .ex_mem_sx(ex_mem_sx), .ex_io_r(ex_io_r), .ex_io_w(ex_io_w),
        .ex_bubble(ex_bubble), .ex_mem_sz(ex_mem_sz),
        .stall_o(stall_o), .bus_req(bus_req), .bus_we(bus_we), .bus_io(bus_io),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_gnt(bus_gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .out_pc(out_pc), .out_res(out_res), .out_rd(out_rd), .out_w_rd(out_w_rd),
        .out_bubble(out_bubble), .misalign_o(misalign_o), .buserr_o(buserr_o)
    );

    int checks = 0;
    int errors = 0;

    // observations of the most recent instruction
    logic        o_done, o_we, o_io, o_wrd, o_bub, o_mis, o_berr;
    int          o_stalls, o_reqs, o_unstable;
    logic [31:0] o_res, o_addr, o_wd, o_pc;
    logic [3:0]  o_be;
    logic [4:0]  o_rd;

    // reference-model instruction and expectations
    logic [31:0] m_pc, m_alu, m_op3;
    logic [4:0]  m_rd;
    logic [1:0]  m_sz;
    logic        m_w_rd, m_link, m_mem_r, m_mem_w, m_sx, m_io_r, m_io_w, m_bub;
    int          e_stalls, e_reqs;
    logic [31:0] e_res, e_addr, e_wd;
    logic [3:0]  e_be;
    logic        e_we, e_io, e_wrd, e_mis, e_berr;

    task automatic idle_inputs();
        ex_bubble = 1'b1; ex_mem_r = 1'b0; ex_mem_w = 1'b0; ex_io_r = 1'b0; ex_io_w = 1'b0;
        ex_link = 1'b0; ex_w_rd = 1'b0; ex_mem_sx = 1'b0; ex_mem_sz = 2'd0;
        ex_pc = 32'h0; ex_nextpc = 32'h4; ex_alu_res = 32'h0; ex_op3 = 32'h0; ex_rd = 5'd0;
    endtask

    task automatic drive_model();
        ex_pc = m_pc; ex_nextpc = m_pc + 32'd4; ex_alu_res = m_alu; ex_op3 = m_op3;
        ex_rd = m_rd; ex_w_rd = m_w_rd; ex_link = m_link; ex_mem_r = m_mem_r;
        ex_mem_w = m_mem_w; ex_mem_sx = m_sx; ex_mem_sz = m_sz; ex_io_r = m_io_r;
        ex_io_w = m_io_w; ex_bubble = m_bub;
    endtask

    task automatic set_op(input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd,
                          input logic mr, input logic mw, input logic ir, input logic iw,
                          input logic [1:0] sz, input logic sx);
        m_pc = 32'h0000_1000; m_alu = a; m_op3 = d; m_rd = rd; m_w_rd = 1'b1; m_link = 1'b0;
        m_mem_r = mr; m_mem_w = mw; m_io_r = ir; m_io_w = iw; m_sz = sz; m_sx = sx; m_bub = 1'b0;
    endtask

    // Plays the bus side for one instruction; rsp_dly counts RESP cycles before the response.
    task automatic run_op(input int gnt_dly, input int rsp_dly, input logic [31:0] word);
        int rc;
        o_done = 1'b0; o_stalls = 0; o_reqs = 0; o_unstable = 0; rc = 0;
        @(posedge clk); #1;
        idle_inputs();
        for (int cyc = 0; cyc < 80 && !o_done; cyc++) begin
            if (!stall_o) begin
                o_done = 1'b1;
            end else begin
                o_stalls++;
                if (bus_req) begin
                    if (o_reqs == 0) begin
                        o_addr = bus_addr; o_be = bus_be; o_wd = bus_wdata; o_we = bus_we; o_io = bus_io;
                    end else if ({bus_addr, bus_be, bus_wdata, bus_we, bus_io} !== {o_addr, o_be, o_wd, o_we, o_io}) begin
                        o_unstable++;
                    end
                    bus_gnt   = (o_reqs == gnt_dly);
                    rsp_valid = !bus_gnt && ($urandom_range(0, 1) == 1);
                    rsp_data  = $urandom;
                    o_reqs++;
                end else begin
                    bus_gnt   = 1'b0;
                    rsp_valid = (rc == rsp_dly);
                    rsp_data  = rsp_valid ? word : $urandom;
                    rc++;
                end
                @(posedge clk); #1;
            end
        end
        bus_gnt = 1'b0; rsp_valid = 1'b0;
        o_res = out_res; o_wrd = out_w_rd; o_bub = out_bubble; o_mis = misalign_o;
        o_berr = buserr_o; o_pc = out_pc; o_rd = out_rd;
    endtask

    // Expected outcome computed from the architectural rules of the stage.
    task automatic model(input int gd, input int rdl, input logic [31:0] word);
        int a;
        logic bus, io, wr;
        logic [31:0] v;
        a   = int'(m_alu % 4);
        io  = m_io_r || m_io_w;
        wr  = m_mem_w || m_io_w;
        bus = (m_mem_r || m_mem_w || io) && !m_bub;
        if (io)             e_mis = bus && (a != 0);
        else if (m_sz == 0) e_mis = 1'b0;
        else if (m_sz == 1) e_mis = bus && (a % 2 != 0);
        else                e_mis = bus && (a != 0);
        e_berr = 1'b0; e_reqs = 0; e_stalls = 0;
        if (bus && !e_mis) begin
            e_reqs = gd + 1;
            e_stalls = e_reqs;
            if (!wr) begin
                if (rdl < TO) e_stalls += rdl + 1;
                else begin e_stalls += TO; e_berr = 1'b1; end
            end
        end
        e_addr = io ? (m_alu % 32'h1_0000) : m_alu;
        e_we = wr; e_io = io;
        e_wd = m_op3 * (32'd1 << (8 * a));
        if (!wr) e_be = 4'd0;
        else if (io || m_sz >= 2) e_be = 4'hF;
        else if (m_sz == 0) e_be = 4'(1 << a);
        else e_be = 4'(3 << a);
        v = word / (32'd1 << (8 * a));
        if (e_berr)         e_res = 32'h0;
        else if (m_link)    e_res = m_pc + 32'd4;
        else if (m_io_r)    e_res = word;
        else if (!m_mem_r)  e_res = m_alu;
        else if (m_sz == 0) begin e_res = v % 256; if (m_sx && e_res >= 128) e_res = e_res - 256; end
        else if (m_sz == 1) begin e_res = v % 65536; if (m_sx && e_res >= 32768) e_res = e_res - 65536; end
        else                e_res = word;
        e_wrd = m_w_rd && !m_bub && !e_mis && !e_berr;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus_gnt = 1'b0; rsp_valid = 1'b0; rsp_data = 32'h0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (stall_o !== 1'b0)   begin errors++; $display("FAIL rst_stall got %b exp 0", stall_o); end
        checks++; if (bus_req !== 1'b0)   begin errors++; $display("FAIL rst_req got %b exp 0", bus_req); end
        checks++; if (out_w_rd !== 1'b0)  begin errors++; $display("FAIL rst_wrd got %b exp 0", out_w_rd); end
        checks++; if ({misalign_o, buserr_o} !== 2'b00) begin errors++; $display("FAIL rst_faults got %b exp 00", {misalign_o, buserr_o}); end
        checks++; if (out_bubble !== 1'b1) begin errors++; $display("FAIL rst_bubble got %b exp 1", out_bubble); end
        checks++; if ({out_res, out_pc, out_rd} !== 69'h0) begin errors++; $display("FAIL rst_data got %h %h %h exp 0", out_res, out_pc, out_rd); end
        checks++; if ({bus_addr, bus_be, bus_wdata} !== 68'h0) begin errors++; $display("FAIL rst_bus got %h %h %h exp 0", bus_addr, bus_be, bus_wdata); end
        rst = 1'b0;
    endtask

    task automatic test_alu();
        set_op(32'h1234, 32'h0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        drive_model();
        run_op(0, 0, 32'h0);
        checks++; if (o_stalls !== 0)       begin errors++; $display("FAIL alu_stall got %0d exp 0", o_stalls); end
        checks++; if (o_reqs !== 0)         begin errors++; $display("FAIL alu_req got %0d exp 0", o_reqs); end
        checks++; if (o_res !== 32'h1234)   begin errors++; $display("FAIL alu_res got %h exp 00001234", o_res); end
        checks++; if (o_wrd !== 1'b1)       begin errors++; $display("FAIL alu_wrd got %b exp 1", o_wrd); end
        checks++; if (o_rd !== 5'd5)        begin errors++; $display("FAIL alu_rd got %0d exp 5", o_rd); end
    endtask

    task automatic test_load_sub();
        set_op(32'h103, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
        drive_model();
        run_op(1, 1, 32'h80FF_FF11);
        checks++; if (o_stalls !== 4)            begin errors++; $display("FAIL lb_stall got %0d exp 4", o_stalls); end
        checks++; if (o_be !== 4'b0000)          begin errors++; $display("FAIL lb_be got %b exp 0000", o_be); end
        checks++; if (o_addr !== 32'h103)        begin errors++; $display("FAIL lb_addr got %h exp 00000103", o_addr); end
        checks++; if (o_res !== 32'hFFFF_FF80)   begin errors++; $display("FAIL lb_res got %h exp ffffff80", o_res); end
        checks++; if (o_wrd !== 1'b1)            begin errors++; $display("FAIL lb_wrd got %b exp 1", o_wrd); end
    endtask

    task automatic test_store_lanes();
        set_op(32'h202, 32'hABCD, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0);
        drive_model();
        run_op(3, 0, 32'h0);
        checks++; if (o_stalls !== 4)          begin errors++; $display("FAIL sh_stall got %0d exp 4", o_stalls); end
        checks++; if (o_unstable !== 0)        begin errors++; $display("FAIL sh_hold got %0d exp 0", o_unstable); end
        checks++; if (o_be !== 4'b1100)        begin errors++; $display("FAIL sh_be got %b exp 1100", o_be); end
        checks++; if (o_wd !== 32'hABCD_0000)  begin errors++; $display("FAIL sh_wdata got %h exp abcd0000", o_wd); end
        checks++; if (o_we !== 1'b1)           begin errors++; $display("FAIL sh_we got %b exp 1", o_we); end
    endtask

    task automatic test_misalign();
        set_op(32'h101, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0);
        drive_model();
        run_op(0, 0, 32'h0);
        checks++; if (o_reqs !== 0)     begin errors++; $display("FAIL mis_req got %0d exp 0", o_reqs); end
        checks++; if (o_mis !== 1'b1)   begin errors++; $display("FAIL mis_pulse got %b exp 1", o_mis); end
        checks++; if (o_wrd !== 1'b0)   begin errors++; $display("FAIL mis_wrd got %b exp 0", o_wrd); end
    endtask

    task automatic test_timeout();
        set_op(32'h4000_0010, 32'h0, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0);
        drive_model();
        run_op(0, 1000, 32'h0);
        checks++; if (o_stalls !== 1 + TO)  begin errors++; $display("FAIL to_stall got %0d exp %0d", o_stalls, 1 + TO); end
        checks++; if (o_addr !== 32'h10)    begin errors++; $display("FAIL to_addr got %h exp 00000010", o_addr); end
        checks++; if (o_berr !== 1'b1)      begin errors++; $display("FAIL to_buserr got %b exp 1", o_berr); end
        checks++; if (o_res !== 32'h0)      begin errors++; $display("FAIL to_res got %h exp 0", o_res); end
        checks++; if (o_wrd !== 1'b0)       begin errors++; $display("FAIL to_wrd got %b exp 0", o_wrd); end
        // response in the very cycle the count expires
        set_op(32'h4000_0020, 32'h0, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0);
        drive_model();
        run_op(0, TO - 1, 32'h5A5A_1234);
        checks++; if (o_berr !== 1'b0)           begin errors++; $display("FAIL to_race_err got %b exp 0", o_berr); end
        checks++; if (o_res !== 32'h5A5A_1234)   begin errors++; $display("FAIL to_race_res got %h exp 5a5a1234", o_res); end
        set_op(32'h77, 32'h0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        drive_model();
        run_op(0, 0, 32'h0);
        checks++; if ({o_res, o_wrd, o_berr} !== {32'h77, 2'b10}) begin errors++; $display("FAIL to_resume got %h %b %b exp 00000077 1 0", o_res, o_wrd, o_berr); end
    endtask

    task automatic test_reset_mid();
        set_op(32'h100, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0);
        drive_model();
        @(posedge clk); #1;
        idle_inputs();
        bus_gnt = 1'b1;
        @(posedge clk); #1;
        bus_gnt = 1'b0;
        checks++; if ({stall_o, bus_req} !== 2'b10) begin errors++; $display("FAIL rm_resp got %b exp 10", {stall_o, bus_req}); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; rsp_valid = 1'b1; rsp_data = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        rsp_valid = 1'b0;
        checks++; if (stall_o !== 1'b0)    begin errors++; $display("FAIL rm_stall got %b exp 0", stall_o); end
        checks++; if (out_bubble !== 1'b1) begin errors++; $display("FAIL rm_bubble got %b exp 1", out_bubble); end
        checks++; if (out_w_rd !== 1'b0)   begin errors++; $display("FAIL rm_wrd got %b exp 0", out_w_rd); end
        checks++; if (bus_req !== 1'b0)    begin errors++; $display("FAIL rm_req got %b exp 0", bus_req); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r0, word;
        int kind, gd, rdl;
        for (int n = 0; n < 150; n++) begin
            r0 = $urandom;
            m_pc = {r0[31:2], 2'b00}; m_alu = $urandom; m_op3 = $urandom; m_rd = r0[8:4];
            m_w_rd = ($urandom_range(0, 3) != 0); m_link = 1'b0; m_mem_r = 1'b0; m_mem_w = 1'b0;
            m_io_r = 1'b0; m_io_w = 1'b0; m_bub = 1'b0;
            m_sz = 2'($urandom_range(0, 3)); m_sx = ($urandom_range(0, 1) == 1);
            kind = $urandom_range(0, 8);
            case (kind)
                1:       m_link = 1'b1;
                2, 7:    m_mem_r = 1'b1;
                3, 8:    m_mem_w = 1'b1;
                4:       m_io_r = 1'b1;
                5:       m_io_w = 1'b1;
                6:       begin m_mem_r = 1'b1; m_bub = 1'b1; end
                default: ;
            endcase
            if (kind >= 2 && $urandom_range(0, 2) != 0) m_alu = m_alu & ~32'h3;
            gd = $urandom_range(0, 3); rdl = $urandom_range(0, 5); word = $urandom;
            drive_model();
            model(gd, rdl, word);
            run_op(gd, rdl, word);
            checks++; if (o_done !== 1'b1)     begin errors++; $display("FAIL b2b_done op %0d never completed", n); end
            checks++; if (o_stalls !== e_stalls) begin errors++; $display("FAIL b2b_stall op %0d got %0d exp %0d", n, o_stalls, e_stalls); end
            checks++; if (o_reqs !== e_reqs)   begin errors++; $display("FAIL b2b_req op %0d got %0d exp %0d", n, o_reqs, e_reqs); end
            checks++; if (o_unstable !== 0)    begin errors++; $display("FAIL b2b_hold op %0d got %0d exp 0", n, o_unstable); end
            if (e_reqs > 0) begin
                checks++; if ({o_addr, o_be, o_wd, o_we, o_io} !== {e_addr, e_be, e_wd, e_we, e_io})
                    begin errors++; $display("FAIL b2b_bus op %0d got %h %b %h %b %b exp %h %b %h %b %b", n, o_addr, o_be, o_wd, o_we, o_io, e_addr, e_be, e_wd, e_we, e_io); end
            end
            checks++; if (o_wrd !== e_wrd)     begin errors++; $display("FAIL b2b_wrd op %0d got %b exp %b", n, o_wrd, e_wrd); end
            checks++; if (o_bub !== m_bub)     begin errors++; $display("FAIL b2b_bubble op %0d got %b exp %b", n, o_bub, m_bub); end
            checks++; if ({o_mis, o_berr} !== {e_mis, e_berr}) begin errors++; $display("FAIL b2b_fault op %0d got %b%b exp %b%b", n, o_mis, o_berr, e_mis, e_berr); end
            checks++; if ({o_pc, o_rd} !== {m_pc, m_rd}) begin errors++; $display("FAIL b2b_tag op %0d got %h %0d exp %h %0d", n, o_pc, o_rd, m_pc, m_rd); end
            if (!e_mis && !m_bub) begin
                checks++; if (o_res !== e_res) begin errors++; $display("FAIL b2b_res op %0d got %h exp %h", n, o_res, e_res); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_sub();
        test_store_lanes();
        test_misalign();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_alu();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
